// File: rtl/melody_sequencer.sv
// Plays tunes from a 16-entry note ROM. Each note is timed in prescaled ticks
// and followed by a silent gap. A second tune request can be queued one deep.
module melody_sequencer #(
   parameter int         TICK_DIV   = 120000,
   parameter logic [7:0] GAP_TICKS  = 8'd2,
   parameter logic [3:0] TUNE0_ADDR = 4'd0,
   parameter logic [3:0] TUNE1_ADDR = 4'd8
) (
   input  logic       clk12MHz,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       abort,
   output logic [7:0] midi,
   output logic       busy,
   output logic       tune,
   output logic       done,
   output logic [2:0] dbg_state
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_PLAY = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    addr_q, addr_d;
   logic [7:0]    midi_q, midi_d;
   logic [7:0]    dcnt_q, dcnt_d;
   logic [7:0]    gcnt_q, gcnt_d;
   logic          busy_q, busy_d;
   logic          tune_q, tune_d;
   logic          pend_q, pend_d;
   logic          pend_id_q, pend_id_d;
   logic          tick;
   logic          req_sel;
   logic [15:0]   rom_q;

   // {note, dur}; dur == 0 terminates a tune, entry 15 is always a terminator.
   function automatic logic [15:0] rom_word(input logic [3:0] a);
      case (a)
         4'd0:    rom_word = {8'd74, 8'd4};
         4'd1:    rom_word = {8'd76, 8'd4};
         4'd2:    rom_word = {8'd72, 8'd4};
         4'd3:    rom_word = {8'd60, 8'd4};
         4'd4:    rom_word = {8'd67, 8'd8};
         4'd8:    rom_word = {8'd60, 8'd2};
         4'd9:    rom_word = {8'd67, 8'd2};
         4'd10:   rom_word = {8'd72, 8'd2};
         default: rom_word = 16'd0;
      endcase
   endfunction

   assign tick    = (presc_q == PW'(TICK_DIV - 1));
   assign req_sel = req[0] ? 1'b0 : 1'b1;
   assign rom_q   = rom_word(addr_q);

   always_comb begin
      state_d   = state_q;
      presc_d   = tick ? '0 : presc_q + 1'b1;
      addr_d    = addr_q;
      midi_d    = midi_q;
      dcnt_d    = dcnt_q;
      gcnt_d    = gcnt_q;
      busy_d    = busy_q;
      tune_d    = tune_q;
      pend_d    = pend_q;
      pend_id_d = pend_id_q;

      // While a tune runs, a request for the other tune replaces any pending one.
      if ((state_q == S_LOAD || state_q == S_PLAY || state_q == S_GAP) &&
          (req != 2'b00) && (req_sel != tune_q)) begin
         pend_d    = 1'b1;
         pend_id_d = req_sel;
      end

      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               addr_d  = req[0] ? TUNE0_ADDR : TUNE1_ADDR;
               tune_d  = req_sel;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (rom_q[7:0] == 8'd0) begin
               state_d = S_DONE;
            end else begin
               midi_d  = rom_q[15:8];
               dcnt_d  = rom_q[7:0];
               presc_d = '0;
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            if (tick) begin
               if (dcnt_q == 8'd1) begin
                  midi_d = 8'd0;
                  if (GAP_TICKS == 8'd0) begin
                     addr_d  = addr_q + 4'd1;
                     state_d = S_LOAD;
                  end else begin
                     gcnt_d  = GAP_TICKS;
                     presc_d = '0;
                     state_d = S_GAP;
                  end
               end else begin
                  dcnt_d = dcnt_q - 8'd1;
               end
            end
         end
         S_GAP: begin
            if (tick) begin
               if (gcnt_q == 8'd1) begin
                  addr_d  = addr_q + 4'd1;
                  state_d = S_LOAD;
               end else begin
                  gcnt_d = gcnt_q - 8'd1;
               end
            end
         end
         S_DONE: begin
            midi_d = 8'd0;
            if (pend_q) begin
               addr_d  = pend_id_q ? TUNE1_ADDR : TUNE0_ADDR;
               tune_d  = pend_id_q;
               pend_d  = 1'b0;
               state_d = S_LOAD;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         midi_d  = 8'd0;
         busy_d  = 1'b0;
         pend_d  = 1'b0;
      end
   end

   always_ff @(posedge clk12MHz or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         addr_q    <= 4'd0;
         midi_q    <= 8'd0;
         dcnt_q    <= 8'd0;
         gcnt_q    <= 8'd0;
         busy_q    <= 1'b0;
         tune_q    <= 1'b0;
         pend_q    <= 1'b0;
         pend_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         addr_q    <= addr_d;
         midi_q    <= midi_d;
         dcnt_q    <= dcnt_d;
         gcnt_q    <= gcnt_d;
         busy_q    <= busy_d;
         tune_q    <= tune_d;
         pend_q    <= pend_d;
         pend_id_q <= pend_id_d;
      end
   end

   assign midi      = midi_q;
   assign busy      = busy_q;
   assign tune      = tune_q;
   assign done      = (state_q == S_DONE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: expected midi segments (note, length)
// are queued per tune and checked as the output changes.
module tb_melody_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req;
   logic       abort;
   logic [7:0] midi;
   logic       busy;
   logic       tune;
   logic       done;
   logic [2:0] dbg_state;

   int          vectors = 0;
   int          errors  = 0;
   logic [23:0] exp_q[$];
   int          d;
   int          dseen;

   always #5 clk = ~clk;

   melody_sequencer #(
      .TICK_DIV  (10),
      .GAP_TICKS (8'd1),
      .TUNE0_ADDR(4'd0),
      .TUNE1_ADDR(4'd8)
   ) dut (
      .clk12MHz (clk),
      .reset    (reset),
      .req      (req),
      .abort    (abort),
      .midi     (midi),
      .busy     (busy),
      .tune     (tune),
      .done     (done),
      .dbg_state(dbg_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic push_seg(input logic [7:0] n, input int len);
      exp_q.push_back({n, len[15:0]});
   endtask

   task automatic push_tune0();
      push_seg(8'd74, 40); push_seg(8'd0, 11);
      push_seg(8'd76, 40); push_seg(8'd0, 11);
      push_seg(8'd72, 40); push_seg(8'd0, 11);
      push_seg(8'd60, 40); push_seg(8'd0, 11);
      push_seg(8'd67, 80);
   endtask

   // Request a tune from IDLE and check the two-edge start latency.
   task automatic start_tune(input logic [1:0] r, input logic exp_tune, input logic [7:0] first);
      req = r;
      @(negedge clk);
      req = 2'b00;
      chk("start_busy", busy, 1);
      chk("start_midi_load", midi, 0);
      chk("start_tune_id", tune, exp_tune);
      @(negedge clk);
      chk("start_first_note", midi, first);
   endtask

   // Watch midi from the first note sample until busy falls, popping one
   // expected segment per midi change. Optional one-cycle req / abort pulses.
   task automatic observe(input int budget, input int inj_c, input logic [1:0] inj_req,
                          input int abort_c, output int dcnt);
      logic [7:0]  prev;
      logic [23:0] e;
      int          run;
      int          last_done;
      logic        fell;
      prev = midi; run = 0; dcnt = 0; last_done = -10; fell = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (midi !== prev) begin
            if (exp_q.size() == 0) begin
               chk("seg_expected", 0, 1);
            end else begin
               e = exp_q.pop_front();
               chk("seg_note", prev, e[23:16]);
               chk("seg_len", run, e[15:0]);
            end
            prev = midi;
            run  = 0;
         end
         run++;
         if (done) begin
            dcnt++;
            last_done = c;
            chk("done_tail", run, 12);
         end
         if (!busy) begin
            fell = 1'b1;
            if (dcnt > 0) chk("busy_fall", c - last_done, 1);
            break;
         end
         req   = (c == inj_c) ? inj_req : 2'b00;
         abort = (c == abort_c);
         @(negedge clk);
      end
      chk("busy_fell", fell, 1);
      chk("queue_empty", exp_q.size(), 0);
      exp_q.delete();
      req   = 2'b00;
      abort = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req   = 2'b00;
      abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_midi", midi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tune", tune, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clk);

      // Full tune 0.
      start_tune(2'b01, 1'b0, 8'd74);
      push_tune0();
      observe(2000, -1, 2'b00, -1, d);
      chk("t0_done_cnt", d, 1);

      // Simultaneous request: tune 0 wins, tune 1 not queued.
      start_tune(2'b11, 1'b0, 8'd74);
      push_tune0();
      observe(2000, -1, 2'b00, -1, d);
      chk("both_done_cnt", d, 1);
      repeat (20) @(negedge clk);
      chk("both_idle_busy", busy, 0);
      chk("both_idle_midi", midi, 0);

      // Tune 1 queued during tune 0 playback.
      start_tune(2'b01, 1'b0, 8'd74);
      push_tune0();
      push_seg(8'd0, 13);
      push_seg(8'd60, 20); push_seg(8'd0, 11);
      push_seg(8'd67, 20); push_seg(8'd0, 11);
      push_seg(8'd72, 20);
      observe(3000, 60, 2'b10, -1, d);
      chk("pend_done_cnt", d, 2);
      chk("pend_tune_id", tune, 1);

      // Abort mid-note with a pending request.
      start_tune(2'b01, 1'b0, 8'd74);
      push_seg(8'd74, 40); push_seg(8'd0, 11);
      push_seg(8'd76, 40); push_seg(8'd0, 11);
      push_seg(8'd72, 9);
      observe(2000, 20, 2'b10, 110, d);
      chk("abort_done_cnt", d, 0);
      dseen = 0;
      for (int i = 0; i < 30; i++) begin
         if (done || busy) dseen++;
         @(negedge clk);
      end
      chk("abort_stays_idle", dseen, 0);
      chk("abort_midi", midi, 0);
      start_tune(2'b01, 1'b0, 8'd74);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort2_busy", busy, 0);
      chk("abort2_midi", midi, 0);

      // Asynchronous reset in the gap of tune 1.
      start_tune(2'b10, 1'b1, 8'd60);
      repeat (25) @(negedge clk);
      chk("gap_midi", midi, 0);
      chk("gap_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_midi", midi, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_tune", tune, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("arst_idle_state", dbg_state, 0);
      chk("arst_idle_busy", busy, 0);
      start_tune(2'b01, 1'b0, 8'd74);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
